// File: rtl/axi4_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_lite_pkg
//  Description : Shared types and constants for the AXI4-Lite master engine:
//                FSM state encoding, FIR slave region codes and the
//                address-field helpers for the region selector bits.
//  Revision    : 1.0  initial release
// ============================================================================
package axi4_lite_pkg;

    // Master FSM states, explicitly encoded
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR      = 3'd3,
        RESP    = 3'd4
    } state_t;

    // Region selector field position within a 32-bit address
    localparam int ADDR_REGION_MSB   = 31;
    localparam int ADDR_REGION_LSB   = 28;
    localparam int ADDR_REGION_WIDTH = ADDR_REGION_MSB - ADDR_REGION_LSB + 1;

    // FIR slave register regions
    localparam logic [ADDR_REGION_WIDTH-1:0] REG_CTRL     = 4'b0000;
    localparam logic [ADDR_REGION_WIDTH-1:0] REG_TAP_NUM  = 4'b0001;
    localparam logic [ADDR_REGION_WIDTH-1:0] REG_DATA_NUM = 4'b0010;
    localparam logic [ADDR_REGION_WIDTH-1:0] REG_TAP_BRAM = 4'b0011;

    // Extract the region selector from a full address
    function automatic logic [ADDR_REGION_WIDTH-1:0] addr_region(input logic [31:0] addr);
        return addr[ADDR_REGION_MSB:ADDR_REGION_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_lite_master_wdog.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_lite_master_wdog
//  Description : Stall watchdog. Counts cycles while enabled, restarts on
//                clear, and flags expiry when the count reaches limit-1.
//                A limit of zero disables expiry entirely.
//  Revision    : 1.0  initial release
// ============================================================================
module axi4_lite_master_wdog #(
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clear,
    input  logic                     i_enable,
    input  logic [TIMEOUT_WIDTH-1:0] i_limit,
    output logic                     o_expire
);

    logic [TIMEOUT_WIDTH-1:0] r_count;

    // Cycle counter: clear has priority so a fresh state starts from zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + TIMEOUT_WIDTH'(1);
        end
    end

    // Expiry is flagged in the last allowed cycle so the abort lands on the
    // following edge, exactly limit cycles after the stalled state began
    always_comb begin
        o_expire = 1'b0;
        if (i_enable && (i_limit != '0) && (r_count == i_limit - TIMEOUT_WIDTH'(1))) begin
            o_expire = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi4_lite_master.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_lite_master
//  Description : Single-outstanding AXI4-Lite master for the FIR config /
//                tap-RAM slave. Runs AR/R or AW/W handshakes for one command
//                at a time, returns read data or completion, and aborts with
//                an error response when the slave stalls past the watchdog.
//                The slave has no B channel, so none is implemented here.
//  Revision    : 1.0  initial release
// ============================================================================
module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter int pADDR_WIDTH   = 32,
    parameter int pDATA_WIDTH   = 32,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic                     aclk,
    input  logic                     areset,
    // command side
    input  logic                     in_cmd_valid,
    output logic                     out_cmd_ready,
    input  logic                     in_cmd_write,
    input  logic [pADDR_WIDTH-1:0]   in_cmd_addr,
    input  logic [pDATA_WIDTH-1:0]   in_cmd_wdata,
    // response side
    output logic                     out_rsp_valid,
    input  logic                     in_rsp_ready,
    output logic [pDATA_WIDTH-1:0]   out_rsp_rdata,
    output logic                     out_rsp_err,
    input  logic [TIMEOUT_WIDTH-1:0] in_timeout,
    // read address channel
    output logic [pADDR_WIDTH-1:0]   out_m_araddr,
    output logic                     out_m_arvalid,
    input  logic                     in_m_arready,
    // read data channel
    input  logic [pDATA_WIDTH-1:0]   in_m_rdata,
    input  logic                     in_m_rvalid,
    output logic                     out_m_rready,
    // write address channel
    output logic [pADDR_WIDTH-1:0]   out_m_awaddr,
    output logic                     out_m_awvalid,
    input  logic                     in_m_awready,
    // write data channel
    output logic [pDATA_WIDTH-1:0]   out_m_wdata,
    output logic                     out_m_wvalid,
    input  logic                     in_m_wready
);

    state_t                   r_state;
    logic                     r_cmd_ready;
    logic [pADDR_WIDTH-1:0]   r_araddr;
    logic                     r_arvalid;
    logic                     r_rready;
    logic [pADDR_WIDTH-1:0]   r_awaddr;
    logic                     r_awvalid;
    logic [pDATA_WIDTH-1:0]   r_wdata;
    logic                     r_wvalid;
    logic                     r_aw_done;
    logic                     r_w_done;
    logic                     r_rsp_valid;
    logic [pDATA_WIDTH-1:0]   r_rsp_rdata;
    logic                     r_rsp_err;

    logic                     w_accept;
    logic                     w_ar_hs;
    logic                     w_r_hs;
    logic                     w_aw_hs;
    logic                     w_w_hs;
    logic                     w_wr_complete;
    logic                     w_wdog_clear;
    logic                     w_wdog_enable;
    logic                     w_expire;

    // Handshake decodes and watchdog control for the current cycle
    always_comb begin
        w_accept      = (r_state == IDLE) && r_cmd_ready && in_cmd_valid;
        w_ar_hs       = r_arvalid && in_m_arready;
        w_r_hs        = r_rready && in_m_rvalid;
        w_aw_hs       = r_awvalid && in_m_awready;
        w_w_hs        = r_wvalid && in_m_wready;
        w_wr_complete = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
        // restart the count on entry to any state that waits on the slave
        w_wdog_clear  = w_accept || ((r_state == RD_ADDR) && w_ar_hs);
        w_wdog_enable = (r_state == RD_ADDR) || (r_state == RD_DATA) || (r_state == WR);
    end

    axi4_lite_master_wdog #(
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_wdog (
        .clk      (aclk),
        .rst      (areset),
        .i_clear  (w_wdog_clear),
        .i_enable (w_wdog_enable),
        .i_limit  (in_timeout),
        .o_expire (w_expire)
    );

    // Master FSM with all outputs registered; a completing handshake always
    // takes priority over a watchdog expiry in the same cycle
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state     <= IDLE;
            r_cmd_ready <= 1'b0;
            r_araddr    <= '0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_awaddr    <= '0;
            r_awvalid   <= 1'b0;
            r_wdata     <= '0;
            r_wvalid    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!r_cmd_ready) begin
                        // one idle cycle before offering the next command slot
                        r_cmd_ready <= 1'b1;
                    end else if (in_cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        if (in_cmd_write) begin
                            r_awaddr  <= in_cmd_addr;
                            r_wdata   <= in_cmd_wdata;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= WR;
                        end else begin
                            r_araddr  <= in_cmd_addr;
                            r_arvalid <= 1'b1;
                            r_state   <= RD_ADDR;
                        end
                    end
                end

                RD_ADDR: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_DATA;
                    end else if (w_expire) begin
                        r_arvalid   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= RESP;
                    end
                end

                RD_DATA: begin
                    if (w_r_hs) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= in_m_rdata;
                        r_rsp_err   <= 1'b0;
                        r_state     <= RESP;
                    end else if (w_expire) begin
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= RESP;
                    end
                end

                WR: begin
                    if (w_wr_complete) begin
                        r_awvalid   <= 1'b0;
                        r_wvalid    <= 1'b0;
                        r_aw_done   <= 1'b0;
                        r_w_done    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= RESP;
                    end else if (w_expire) begin
                        r_awvalid   <= 1'b0;
                        r_wvalid    <= 1'b0;
                        r_aw_done   <= 1'b0;
                        r_w_done    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        // channels finish independently; drop each valid after its own beat
                        if (w_aw_hs) begin
                            r_awvalid <= 1'b0;
                            r_aw_done <= 1'b1;
                        end
                        if (w_w_hs) begin
                            r_wvalid <= 1'b0;
                            r_w_done <= 1'b1;
                        end
                    end
                end

                RESP: begin
                    if (in_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign out_cmd_ready = r_cmd_ready;
    assign out_rsp_valid = r_rsp_valid;
    assign out_rsp_rdata = r_rsp_rdata;
    assign out_rsp_err   = r_rsp_err;
    assign out_m_araddr  = r_araddr;
    assign out_m_arvalid = r_arvalid;
    assign out_m_rready  = r_rready;
    assign out_m_awaddr  = r_awaddr;
    assign out_m_awvalid = r_awvalid;
    assign out_m_wdata   = r_wdata;
    assign out_m_wvalid  = r_wvalid;

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi4_lite_master
//  Description : Directed self-checking bench for axi4_lite_master.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_axi4_lite_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TW = 8;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [TW-1:0] timeout;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rready;
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic          wvalid;
    logic          wready;

    int n_checks = 0;
    int n_errors = 0;

    axi4_lite_master #(
        .pADDR_WIDTH   (AW),
        .pDATA_WIDTH   (DW),
        .TIMEOUT_WIDTH (TW)
    ) dut (
        .aclk          (clk),
        .areset        (rst),
        .in_cmd_valid  (cmd_valid),
        .out_cmd_ready (cmd_ready),
        .in_cmd_write  (cmd_write),
        .in_cmd_addr   (cmd_addr),
        .in_cmd_wdata  (cmd_wdata),
        .out_rsp_valid (rsp_valid),
        .in_rsp_ready  (rsp_ready),
        .out_rsp_rdata (rsp_rdata),
        .out_rsp_err   (rsp_err),
        .in_timeout    (timeout),
        .out_m_araddr  (araddr),
        .out_m_arvalid (arvalid),
        .in_m_arready  (arready),
        .in_m_rdata    (rdata),
        .in_m_rvalid   (rvalid),
        .out_m_rready  (rready),
        .out_m_awaddr  (awaddr),
        .out_m_awvalid (awvalid),
        .in_m_awready  (awready),
        .out_m_wdata   (wdata),
        .out_m_wvalid  (wvalid),
        .in_m_wready   (wready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // advance one clock and sample 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // wait (bounded) for cmd_ready, present one command, return just after the accepting edge
    task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            tick();
            guard++;
        end
        check_val("cmd_ready_before_issue", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        logic ok;
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        timeout   = 8'd20;
        arready   = 1'b0;
        rdata     = '0;
        rvalid    = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;

        // ---------------- reset state ----------------
        #1 rst = 1'b1;
        #1;
        check_val("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_val("rst_outputs",   32'({arvalid, rready, awvalid, wvalid, rsp_valid, rsp_err}), 32'd0);
        check_val("rst_araddr",    araddr, 32'd0);
        check_val("rst_rsp_rdata", rsp_rdata, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        check_val("cmd_ready_low_after_release", 32'(cmd_ready), 32'd0);
        tick();
        check_val("cmd_ready_rises", 32'(cmd_ready), 32'd1);

        // ---------------- write, zero-wait slave ----------------
        awready = 1'b1;
        wready  = 1'b1;
        issue_cmd(1'b1, 32'h1000_0000, 32'h0000_000B);
        check_val("wr0_valids_up", 32'({awvalid, wvalid}), 32'd3);
        check_val("wr0_awaddr",    awaddr, 32'h1000_0000);
        check_val("wr0_wdata",     wdata, 32'h0000_000B);
        check_val("wr0_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        check_val("wr0_valids_down", 32'({awvalid, wvalid}), 32'd0);
        check_val("wr0_rsp_valid",   32'(rsp_valid), 32'd1);
        check_val("wr0_rsp_err",     32'(rsp_err), 32'd0);
        check_val("wr0_rsp_rdata",   rsp_rdata, 32'd0);
        tick();
        check_val("wr0_rsp_done",     32'(rsp_valid), 32'd0);
        check_val("wr0_ready_gap",    32'(cmd_ready), 32'd0);
        tick();
        check_val("wr0_ready_return", 32'(cmd_ready), 32'd1);

        // ---------------- write, W first, AW at cycle 4, response stalled ----------------
        awready   = 1'b0;
        wready    = 1'b1;
        rsp_ready = 1'b0;
        issue_cmd(1'b1, 32'h0000_0004, 32'h0000_0055);
        check_val("wr1_both_valid", 32'({awvalid, wvalid}), 32'd3);
        tick();
        wready = 1'b0;
        check_val("wr1_w_dropped", 32'({awvalid, wvalid}), 32'd2);
        tick();
        tick();
        check_val("wr1_aw_held", 32'({awvalid, wvalid, rsp_valid}), 32'd4);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        check_val("wr1_rsp_valid",  32'({awvalid, rsp_valid}), 32'd1);
        check_val("wr1_rsp_err",    32'(rsp_err), 32'd0);
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (!rsp_valid || rsp_err || rsp_rdata != 32'd0 || cmd_ready) ok = 1'b0;
        end
        check_val("rsp_stall_stable", 32'(ok), 32'd1);
        rsp_ready = 1'b1;
        tick();
        check_val("rsp_stall_release", 32'({rsp_valid, cmd_ready}), 32'd0);

        // ---------------- read with wait states ----------------
        arready = 1'b0;
        issue_cmd(1'b0, 32'h3000_0008, 32'h0);
        check_val("rd_arvalid", 32'(arvalid), 32'd1);
        check_val("rd_araddr",  araddr, 32'h3000_0008);
        tick();
        tick();
        check_val("rd_araddr_held", araddr, 32'h3000_0008);
        check_val("rd_arvalid_held", 32'({arvalid, rready}), 32'd2);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check_val("rd_addr_done", 32'({arvalid, rready}), 32'd1);
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (!rready || rsp_valid) ok = 1'b0;
            if (i < 2) tick();
        end
        check_val("rd_data_wait", 32'(ok), 32'd1);
        rdata  = 32'hFFFF_FFF6;
        rvalid = 1'b1;
        tick();
        rvalid = 1'b0;
        rdata  = '0;
        check_val("rd_rsp_valid", 32'({rsp_valid, rready}), 32'd2);
        check_val("rd_rsp_rdata", rsp_rdata, 32'hFFFF_FFF6);
        check_val("rd_rsp_err",   32'(rsp_err), 32'd0);
        tick();

        // ---------------- watchdog abort, in_timeout = 5 ----------------
        timeout   = 8'd5;
        rsp_ready = 1'b0;
        issue_cmd(1'b0, 32'h2000_0000, 32'h0);
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (!arvalid || rsp_valid) ok = 1'b0;
        end
        check_val("wdog_arvalid_5cyc", 32'(ok), 32'd1);
        tick();
        check_val("wdog_abort_valids", 32'({arvalid, rready}), 32'd0);
        check_val("wdog_rsp_valid",    32'(rsp_valid), 32'd1);
        check_val("wdog_rsp_err",      32'(rsp_err), 32'd1);
        check_val("wdog_rsp_rdata",    rsp_rdata, 32'd0);
        rsp_ready = 1'b1;
        tick();

        // ---------------- watchdog disabled: indefinite wait ----------------
        timeout = 8'd0;
        issue_cmd(1'b0, 32'h0000_0010, 32'h0);
        ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (!arvalid || rsp_valid) ok = 1'b0;
        end
        check_val("wdog_disabled_wait", 32'(ok), 32'd1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rdata   = 32'h1234_5678;
        rvalid  = 1'b1;
        tick();
        rvalid = 1'b0;
        check_val("wdog_disabled_rdata", rsp_rdata, 32'h1234_5678);
        tick();
        timeout = 8'd20;

        // ---------------- async reset while in WR ----------------
        awready = 1'b0;
        wready  = 1'b0;
        issue_cmd(1'b1, 32'h0000_0020, 32'hDEAD_BEEF);
        tick();
        check_val("rstwr_awvalid_before", 32'(awvalid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("rstwr_async_clear", 32'({awvalid, wvalid, cmd_ready, rsp_valid, rsp_err}), 32'd0);
        check_val("rstwr_awaddr", awaddr, 32'd0);
        check_val("rstwr_wdata",  wdata, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        check_val("rstwr_ready_low", 32'(cmd_ready), 32'd0);
        tick();
        check_val("rstwr_ready_back", 32'(cmd_ready), 32'd1);
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid || awvalid || wvalid) ok = 1'b0;
        end
        check_val("rstwr_no_response", 32'(ok), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
